// File: rtl/seg7_pkg.sv
// Shared seven-segment types, active-low glyph constants and the BCD decoder
// function used by the multiplexed display driver.
package seg7_pkg;

  // seg[0] is segment a, seg[6] is segment g.
  typedef logic [0:6] seg7_t;

  localparam seg7_t SEG_0     = 7'b0000001;
  localparam seg7_t SEG_1     = 7'b1001111;
  localparam seg7_t SEG_2     = 7'b0010010;
  localparam seg7_t SEG_3     = 7'b0000110;
  localparam seg7_t SEG_4     = 7'b1001100;
  localparam seg7_t SEG_5     = 7'b0100100;
  localparam seg7_t SEG_6     = 7'b0100000;
  localparam seg7_t SEG_7     = 7'b0001111;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0000100;
  localparam seg7_t SEG_DASH  = 7'b1111110;
  localparam seg7_t SEG_BLANK = 7'b1111111;

  // Non-BCD nibbles (10..15) render as a dash so bad data is visible on the board.
  function automatic seg7_t bcd2seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  assign seg = bcd2seg(bcd);

endmodule

// File: rtl/seg7_mux_driver.sv
// Multiplexed N-digit seven-segment driver: double-buffered BCD capture,
// slot-based digit scan with dead time, leading-zero suppression, registered outputs.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_blank,
  output logic [0:6]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Everything is computed in active-low form; INV flips it at the output register.
  localparam logic INV = ~ACTIVE_LOW;

  logic [4*N_DIGITS-1:0] shadow_digits;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;

  logic [N_DIGITS-1:0]   blank_mask;
  logic [3:0]            cur_bcd;
  logic                  cur_dp;
  logic                  cur_blank;
  seg7_t                 cur_seg;
  logic                  in_dead;

  seg7_t                 seg_al;
  logic                  dp_al;
  logic [N_DIGITS-1:0]   an_al;

  // NOTE: the shadow is a handful of flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
    end else if (load) begin
      shadow_digits <= digits;
      shadow_dp     <= dp_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // NOTE: blocking assignments here on purpose: 'seen' is a running OR carried down the loop.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    blank_mask = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      seen          = seen | (|shadow_digits[4*k +: 4]);
      blank_mask[k] = lz_blank & ~seen;
    end
    blank_mask[0] = 1'b0;
  end

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_bcd   = shadow_digits[4*k +: 4];
        cur_dp    = shadow_dp[k];
        cur_blank = blank_mask[k];
      end
    end
  end

  seg7_decode u_decode (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  generate
    if (DEAD_CYCLES > 0) begin : g_dead
      assign in_dead = (cnt < CNT_W'(DEAD_CYCLES));
    end else begin : g_no_dead
      assign in_dead = 1'b0;
    end
  endgenerate

  always_comb begin
    seg_al = cur_blank ? SEG_BLANK : cur_seg;
    dp_al  = ~(cur_dp & ~cur_blank);
    an_al  = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      an_al[k] = in_dead | (idx != IDX_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK ^ {7{INV}};
      dp  <= 1'b1 ^ INV;
      an  <= {N_DIGITS{1'b1}} ^ {N_DIGITS{INV}};
    end else begin
      seg <= seg_al ^ {7{INV}};
      dp  <= dp_al ^ INV;
      an  <= an_al ^ {N_DIGITS{INV}};
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver: an active-low and an active-high instance
// share stimulus; every scan cycle is compared against hand-derived patterns.
module tb_seg7_mux_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int DC = 2;

  localparam logic [0:6] S0 = 7'b0000001;
  localparam logic [0:6] S1 = 7'b1001111;
  localparam logic [0:6] S2 = 7'b0010010;
  localparam logic [0:6] S3 = 7'b0000110;
  localparam logic [0:6] S4 = 7'b1001100;
  localparam logic [0:6] S5 = 7'b0100100;
  localparam logic [0:6] S6 = 7'b0100000;
  localparam logic [0:6] S7 = 7'b0001111;
  localparam logic [0:6] S8 = 7'b0000000;
  localparam logic [0:6] S9 = 7'b0000100;
  localparam logic [0:6] SD = 7'b1111110;
  localparam logic [0:6] SB = 7'b1111111;

  typedef logic [0:6] seg_arr_t [4];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;

  logic [0:6]  seg_l, seg_h;
  logic        dp_l, dp_h;
  logic [3:0]  an_l, an_h;

  int compared = 0;
  int mismatched = 0;
  int cyc;

  logic [23:0] obs;
  logic [23:0] exp_v;
  assign obs = {an_l, seg_l, dp_l, an_h, seg_h, dp_h};

  seg7_mux_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .load(load), .digits(digits), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg_l), .dp(dp_l), .an(an_l)
  );

  seg7_mux_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .load(load), .digits(digits), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg_h), .dp(dp_h), .an(an_h)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release; at a falling edge the outputs reflect cycle cyc-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected {an,seg,dp} for both polarities given the per-digit glyphs and lit dp mask.
  function automatic logic [23:0] expect_vec(input seg_arr_t es, input logic [3:0] lit);
    int c, i;
    logic [3:0] ean;
    logic [0:6] eseg;
    logic edp;
    c    = cyc - 1;
    i    = (c / RD) % N;
    ean  = ((c % RD) < DC) ? 4'b1111 : ~(4'b0001 << i);
    eseg = es[i];
    edp  = ~lit[i];
    return {ean, eseg, edp, ~ean, ~eseg, ~edp};
  endfunction

  task automatic load_now(input logic [15:0] d, input logic [3:0] p);
    digits = d;
    dp_in  = p;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic test_reset();
    seg_arr_t z;
    z = '{S0, S0, S0, S0};
    repeat (3) @(negedge clk);
    exp_v = {4'b1111, 7'b1111111, 1'b1, 4'b0000, 7'b0000000, 1'b0};
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("FAIL reset_state got=%b want=%b", obs, exp_v);
    end
    rst_n = 1'b1;
    repeat (2 * N * RD) begin
      step();
      exp_v = expect_vec(z, 4'b0000);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL reset_release cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
  endtask

  task automatic test_basic_scan();
    seg_arr_t old_s, new_s;
    old_s = '{S0, S0, S0, S0};
    new_s = '{S4, S3, S2, S1};
    load_now(16'h1234, 4'b0000);
    // One edge after capture the outputs still show the previous shadow contents.
    exp_v = expect_vec(old_s, 4'b0000);
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("FAIL load_latency_old cyc=%0d got=%b want=%b", cyc, obs, exp_v);
    end
    repeat (N * RD) begin
      step();
      exp_v = expect_vec(new_s, 4'b0000);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL basic_scan cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
  endtask

  task automatic test_lz_blank();
    seg_arr_t bl, nb;
    bl = '{S0, S7, SB, SB};
    nb = '{S0, S7, S0, S0};
    lz_blank = 1'b1;
    load_now(16'h0070, 4'b0000);
    repeat (N * RD) begin
      step();
      exp_v = expect_vec(bl, 4'b0000);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL lz_on cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
    lz_blank = 1'b0;
    step();
    repeat (N * RD) begin
      step();
      exp_v = expect_vec(nb, 4'b0000);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL lz_off cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
  endtask

  task automatic test_dash_dp();
    seg_arr_t a, b;
    a = '{S5, S0, S0, SD};
    b = '{S5, SB, SB, SB};
    lz_blank = 1'b1;
    load_now(16'hA005, 4'b0100);
    repeat (N * RD) begin
      step();
      exp_v = expect_vec(a, 4'b0100);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL dash_dp cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
    // A blanked digit suppresses its decimal point too; digit 0 is never blanked.
    load_now(16'h0005, 4'b0100);
    step();
    repeat (N * RD) begin
      step();
      exp_v = expect_vec(b, 4'b0000);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL dp_blanked cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_decode_codes();
    seg_arr_t a, b;
    a = '{S6, S7, S8, S9};
    b = '{SD, SD, SD, S0};
    load_now(16'h9876, 4'b1001);
    step();
    repeat (N * RD) begin
      step();
      exp_v = expect_vec(a, 4'b1001);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL decode_6789 cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
    load_now(16'h0EDF, 4'b0000);
    step();
    repeat (N * RD) begin
      step();
      exp_v = expect_vec(b, 4'b0000);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL decode_def cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    seg_arr_t a;
    a = '{S8, S6, S4, S2};
    digits = 16'h1111;
    dp_in  = 4'b1111;
    load   = 1'b1;
    step();
    digits = 16'h2468;
    dp_in  = 4'b0010;
    step();
    load   = 1'b0;
    step();
    repeat (N * RD) begin
      step();
      exp_v = expect_vec(a, 4'b0010);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
  endtask

  task automatic test_load_at_wrap();
    seg_arr_t old_s, new_s;
    old_s = '{S8, S6, S4, S2};
    new_s = '{S7, S5, S3, S1};
    // Align so the next rising edge is the one where cnt wraps 7 -> 0.
    for (int g = 0; g < RD && (cyc % RD) != RD - 1; g++) step();
    load_now(16'h1357, 4'b0000);
    exp_v = expect_vec(old_s, 4'b0010);
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("FAIL wrap_last_old cyc=%0d got=%b want=%b", cyc, obs, exp_v);
    end
    repeat (N * RD) begin
      step();
      exp_v = expect_vec(new_s, 4'b0000);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL wrap_new cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_midscan();
    seg_arr_t z;
    z = '{S0, S0, S0, S0};
    for (int g = 0; g < 13; g++) step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_v = {4'b1111, 7'b1111111, 1'b1, 4'b0000, 7'b0000000, 1'b0};
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("FAIL midscan_async got=%b want=%b", obs, exp_v);
    end
    step();
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("FAIL midscan_held got=%b want=%b", obs, exp_v);
    end
    rst_n = 1'b1;
    repeat (N * RD) begin
      step();
      exp_v = expect_vec(z, 4'b0000);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL midscan_restart cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_scan();
    test_lz_blank();
    test_dash_dp();
    test_decode_codes();
    test_back_to_back();
    test_load_at_wrap();
    test_reset_midscan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
